// File: rtl/axi_id_remapper.sv
// AXI ID remapper: dynamically maps wide upstream IDs onto a narrow downstream
// ID space, one independent slot table for writes (AW/B) and one for reads (AR/R).

module axi_id_remap_table #(
  parameter int MASTER_ID_WIDTH  = 8,
  parameter int SLAVE_ID_WIDTH   = 2,
  parameter int ACTIVE_CNT_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [MASTER_ID_WIDTH-1:0]  req_id,
  input  logic                        req_valid,
  output logic                        req_ready,
  output logic [SLAVE_ID_WIDTH-1:0]   fwd_id,
  output logic                        fwd_valid,
  input  logic                        fwd_ready,
  input  logic [SLAVE_ID_WIDTH-1:0]   rsp_id,
  input  logic                        rsp_valid,
  input  logic                        rsp_ready,
  input  logic                        rsp_last,
  output logic [MASTER_ID_WIDTH-1:0]  rsp_orig_id
);

  localparam int N = 1 << SLAVE_ID_WIDTH;
  localparam logic [ACTIVE_CNT_WIDTH-1:0] CNT_MAX = {ACTIVE_CNT_WIDTH{1'b1}};
  localparam logic [ACTIVE_CNT_WIDTH-1:0] CNT_ONE = ACTIVE_CNT_WIDTH'(1);

  logic [MASTER_ID_WIDTH-1:0]  orig_q [N];
  logic [ACTIVE_CNT_WIDTH-1:0] cnt_q  [N];

  logic                      hit, free_found, fwd;
  logic [SLAVE_ID_WIDTH-1:0] hit_idx, free_idx, sel;
  logic                      inc, dec;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!hit && cnt_q[i] != '0 && orig_q[i] == req_id) begin
        hit     = 1'b1;
        hit_idx = SLAVE_ID_WIDTH'(i);
      end
      if (!free_found && cnt_q[i] == '0) begin
        free_found = 1'b1;
        free_idx   = SLAVE_ID_WIDTH'(i);
      end
    end
    // A live ID must stay on its slot, so a saturated hit stalls rather than
    // falling back to a free slot.
    fwd = hit ? (cnt_q[hit_idx] != CNT_MAX) : free_found;
    sel = hit ? hit_idx : free_idx;
  end

  assign fwd_id      = sel;
  assign fwd_valid   = !rst && req_valid && fwd;
  assign req_ready   = !rst && fwd && fwd_ready;
  assign rsp_orig_id = orig_q[rsp_id];

  assign inc = req_valid && fwd && fwd_ready;
  assign dec = rsp_valid && rsp_ready && rsp_last;

  // NOTE: the table is small control state whose cnt==0 defines "free", so it
  // is reset explicitly (unlike a data RAM, which would be left unreset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        orig_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        // NOTE: sequential state uses non-blocking assignments so every slot
        // sees the pre-edge table regardless of statement order.
        if (inc && sel == SLAVE_ID_WIDTH'(i) && !(dec && rsp_id == SLAVE_ID_WIDTH'(i))) begin
          orig_q[i] <= req_id;
          cnt_q[i]  <= cnt_q[i] + CNT_ONE;
        end else if (dec && rsp_id == SLAVE_ID_WIDTH'(i) && !(inc && sel == SLAVE_ID_WIDTH'(i))) begin
          cnt_q[i]  <= cnt_q[i] - CNT_ONE;
        end
      end
    end
  end

endmodule

module axi_id_remapper #(
  parameter int MASTER_ID_WIDTH  = 8,
  parameter int SLAVE_ID_WIDTH   = 2,
  parameter int ACTIVE_CNT_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [MASTER_ID_WIDTH-1:0]  master_aw_id,
  input  logic                        master_aw_valid,
  output logic                        master_aw_ready,
  input  logic [MASTER_ID_WIDTH-1:0]  master_ar_id,
  input  logic                        master_ar_valid,
  output logic                        master_ar_ready,
  output logic [SLAVE_ID_WIDTH-1:0]   slave_aw_id,
  output logic                        slave_aw_valid,
  input  logic                        slave_aw_ready,
  output logic [SLAVE_ID_WIDTH-1:0]   slave_ar_id,
  output logic                        slave_ar_valid,
  input  logic                        slave_ar_ready,
  input  logic [SLAVE_ID_WIDTH-1:0]   slave_b_id,
  input  logic                        slave_b_valid,
  output logic                        slave_b_ready,
  input  logic [SLAVE_ID_WIDTH-1:0]   slave_r_id,
  input  logic                        slave_r_valid,
  input  logic                        slave_r_last,
  output logic                        slave_r_ready,
  output logic [MASTER_ID_WIDTH-1:0]  master_b_id,
  output logic                        master_b_valid,
  input  logic                        master_b_ready,
  output logic [MASTER_ID_WIDTH-1:0]  master_r_id,
  output logic                        master_r_valid,
  input  logic                        master_r_ready
);

  // B and R handshakes are pure pass-through; only the IDs are translated.
  assign master_b_valid = slave_b_valid;
  assign slave_b_ready  = master_b_ready;
  assign master_r_valid = slave_r_valid;
  assign slave_r_ready  = master_r_ready;

  axi_id_remap_table #(
    .MASTER_ID_WIDTH  (MASTER_ID_WIDTH),
    .SLAVE_ID_WIDTH   (SLAVE_ID_WIDTH),
    .ACTIVE_CNT_WIDTH (ACTIVE_CNT_WIDTH)
  ) u_wr_table (
    .clk         (clk),
    .rst         (rst),
    .req_id      (master_aw_id),
    .req_valid   (master_aw_valid),
    .req_ready   (master_aw_ready),
    .fwd_id      (slave_aw_id),
    .fwd_valid   (slave_aw_valid),
    .fwd_ready   (slave_aw_ready),
    .rsp_id      (slave_b_id),
    .rsp_valid   (slave_b_valid),
    .rsp_ready   (master_b_ready),
    .rsp_last    (1'b1),
    .rsp_orig_id (master_b_id)
  );

  axi_id_remap_table #(
    .MASTER_ID_WIDTH  (MASTER_ID_WIDTH),
    .SLAVE_ID_WIDTH   (SLAVE_ID_WIDTH),
    .ACTIVE_CNT_WIDTH (ACTIVE_CNT_WIDTH)
  ) u_rd_table (
    .clk         (clk),
    .rst         (rst),
    .req_id      (master_ar_id),
    .req_valid   (master_ar_valid),
    .req_ready   (master_ar_ready),
    .fwd_id      (slave_ar_id),
    .fwd_valid   (slave_ar_valid),
    .fwd_ready   (slave_ar_ready),
    .rsp_id      (slave_r_id),
    .rsp_valid   (slave_r_valid),
    .rsp_ready   (master_r_ready),
    .rsp_last    (slave_r_last),
    .rsp_orig_id (master_r_id)
  );

endmodule

// File: tb/tb_axi_id_remapper.sv
// Self-checking bench for axi_id_remapper: directed scenarios plus randomized
// traffic, checked every cycle against a slot-ownership reference model.

module tb_axi_id_remapper;

  localparam int MW   = 6;
  localparam int SW   = 2;
  localparam int CW   = 2;
  localparam int N    = 4;
  localparam int MAXC = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [MW-1:0] master_aw_id = '0, master_ar_id = '0;
  logic          master_aw_valid = 1'b0, master_ar_valid = 1'b0;
  logic          master_aw_ready, master_ar_ready;
  logic [SW-1:0] slave_aw_id, slave_ar_id;
  logic          slave_aw_valid, slave_ar_valid;
  logic          slave_aw_ready = 1'b1, slave_ar_ready = 1'b1;
  logic [SW-1:0] slave_b_id = '0, slave_r_id = '0;
  logic          slave_b_valid = 1'b0, slave_r_valid = 1'b0, slave_r_last = 1'b0;
  logic          slave_b_ready, slave_r_ready;
  logic [MW-1:0] master_b_id, master_r_id;
  logic          master_b_valid, master_r_valid;
  logic          master_b_ready = 1'b1, master_r_ready = 1'b1;

  axi_id_remapper #(
    .MASTER_ID_WIDTH  (MW),
    .SLAVE_ID_WIDTH   (SW),
    .ACTIVE_CNT_WIDTH (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .master_aw_id    (master_aw_id),
    .master_aw_valid (master_aw_valid),
    .master_aw_ready (master_aw_ready),
    .master_ar_id    (master_ar_id),
    .master_ar_valid (master_ar_valid),
    .master_ar_ready (master_ar_ready),
    .slave_aw_id     (slave_aw_id),
    .slave_aw_valid  (slave_aw_valid),
    .slave_aw_ready  (slave_aw_ready),
    .slave_ar_id     (slave_ar_id),
    .slave_ar_valid  (slave_ar_valid),
    .slave_ar_ready  (slave_ar_ready),
    .slave_b_id      (slave_b_id),
    .slave_b_valid   (slave_b_valid),
    .slave_b_ready   (slave_b_ready),
    .slave_r_id      (slave_r_id),
    .slave_r_valid   (slave_r_valid),
    .slave_r_last    (slave_r_last),
    .slave_r_ready   (slave_r_ready),
    .master_b_id     (master_b_id),
    .master_b_valid  (master_b_valid),
    .master_b_ready  (master_b_ready),
    .master_r_id     (master_r_id),
    .master_r_valid  (master_r_valid),
    .master_r_ready  (master_r_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: which upstream ID owns each slot and how many are in flight.
  int w_own [N];
  int w_cnt [N];
  int r_own [N];
  int r_cnt [N];

  // Values observed at the last sample point, for scenario-level checks.
  logic          obs_aw_v, obs_aw_rdy, obs_ar_v, obs_ar_rdy;
  logic [SW-1:0] obs_aw_id, obs_ar_id;
  logic [MW-1:0] obs_b_id, obs_r_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      w_own[i] = 0; w_cnt[i] = 0; r_own[i] = 0; r_cnt[i] = 0;
    end
  endtask

  // Same live ID reuses its slot (granted below the limit); else lowest free slot.
  task automatic lookup(input bit rd, input int id, output bit grant, output int slot);
    int own [N];
    int cnt [N];
    bit done;
    if (rd) begin own = r_own; cnt = r_cnt; end
    else    begin own = w_own; cnt = w_cnt; end
    grant = 1'b0; slot = 0; done = 1'b0;
    for (int i = 0; i < N; i++)
      if (!done && cnt[i] > 0 && own[i] == id) begin
        done = 1'b1; slot = i; grant = (cnt[i] < MAXC);
      end
    for (int i = 0; i < N; i++)
      if (!done && cnt[i] == 0) begin
        done = 1'b1; slot = i; grant = 1'b1;
      end
  endtask

  // One clock: check all outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    bit wg, rg;
    int ws, rs;
    @(negedge clk);
    lookup(1'b0, int'(master_aw_id), wg, ws);
    lookup(1'b1, int'(master_ar_id), rg, rs);
    obs_aw_v = slave_aw_valid; obs_aw_id = slave_aw_id; obs_aw_rdy = master_aw_ready;
    obs_ar_v = slave_ar_valid; obs_ar_id = slave_ar_id; obs_ar_rdy = master_ar_ready;
    obs_b_id = master_b_id;    obs_r_id = master_r_id;
    check("aw_valid", 32'(slave_aw_valid), 32'(master_aw_valid && wg));
    if (master_aw_valid && wg) check("aw_id", 32'(slave_aw_id), 32'(ws));
    check("aw_ready", 32'(master_aw_ready), 32'(wg && slave_aw_ready));
    check("ar_valid", 32'(slave_ar_valid), 32'(master_ar_valid && rg));
    if (master_ar_valid && rg) check("ar_id", 32'(slave_ar_id), 32'(rs));
    check("ar_ready", 32'(master_ar_ready), 32'(rg && slave_ar_ready));
    check("b_valid", 32'(master_b_valid), 32'(slave_b_valid));
    check("b_ready", 32'(slave_b_ready), 32'(master_b_ready));
    check("r_valid", 32'(master_r_valid), 32'(slave_r_valid));
    check("r_ready", 32'(slave_r_ready), 32'(master_r_ready));
    if (slave_b_valid) begin
      assert (w_cnt[slave_b_id] > 0) else $error("B response on idle slot %0d", slave_b_id);
      check("b_id", 32'(master_b_id), 32'(w_own[slave_b_id]));
    end
    if (slave_r_valid) begin
      assert (r_cnt[slave_r_id] > 0) else $error("R response on idle slot %0d", slave_r_id);
      check("r_id", 32'(master_r_id), 32'(r_own[slave_r_id]));
    end
    @(posedge clk);
    if (slave_b_valid && master_b_ready) w_cnt[slave_b_id]--;
    if (master_aw_valid && wg && slave_aw_ready) begin
      w_own[ws] = int'(master_aw_id); w_cnt[ws]++;
    end
    if (slave_r_valid && master_r_ready && slave_r_last) r_cnt[slave_r_id]--;
    if (master_ar_valid && rg && slave_ar_ready) begin
      r_own[rs] = int'(master_ar_id); r_cnt[rs]++;
    end
    #1;
  endtask

  task automatic idle();
    master_aw_valid = 1'b0; master_ar_valid = 1'b0;
    slave_b_valid   = 1'b0; slave_r_valid   = 1'b0; slave_r_last = 1'b0;
    slave_aw_ready  = 1'b1; slave_ar_ready  = 1'b1;
    master_b_ready  = 1'b1; master_r_ready  = 1'b1;
  endtask

  task automatic aw(input int id);
    master_aw_valid = 1'b1; master_aw_id = MW'(id);
  endtask

  task automatic b(input int slot);
    slave_b_valid = 1'b1; slave_b_id = SW'(slot);
  endtask

  // Return every outstanding transaction so the next scenario starts clean.
  task automatic drain();
    idle();
    for (int s = 0; s < N; s++) begin
      while (w_cnt[s] > 0) begin b(s); cycle(); end
      slave_b_valid = 1'b0;
      while (r_cnt[s] > 0) begin
        slave_r_valid = 1'b1; slave_r_id = SW'(s); slave_r_last = 1'b1; cycle();
      end
      slave_r_valid = 1'b0;
    end
    idle();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    model_clear();
    aw(8'h2A); master_ar_valid = 1'b1; master_ar_id = 6'h15;
    slave_aw_ready = 1'b1; slave_ar_ready = 1'b1;
    b(2); slave_r_valid = 1'b1; slave_r_id = 2'd3;
    @(negedge clk);
    check({tag, "_aw_valid"}, 32'(slave_aw_valid), 32'd0);
    check({tag, "_aw_ready"}, 32'(master_aw_ready), 32'd0);
    check({tag, "_ar_valid"}, 32'(slave_ar_valid), 32'd0);
    check({tag, "_ar_ready"}, 32'(master_ar_ready), 32'd0);
    check({tag, "_b_id"}, 32'(master_b_id), 32'd0);
    check({tag, "_r_id"}, 32'(master_r_id), 32'd0);
    check({tag, "_b_pass"}, 32'(master_b_valid), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
  endtask

  initial begin
    model_clear();
    do_reset("reset");

    // Basic write: first AW right after reset lands on slot 0 in the same cycle.
    aw(8'h2A); cycle();
    check("basic_aw_slot", 32'(obs_aw_id), 32'd0);
    check("basic_aw_ready", 32'(obs_aw_rdy), 32'd1);
    idle(); b(0); cycle();
    check("basic_b_id", 32'(obs_b_id), 32'h2A);
    idle(); aw(8'h15); cycle();
    check("basic_slot0_free", 32'(obs_aw_id), 32'd0);
    drain();

    // Per-slot limit: fourth outstanding 0x11 stalls until a B frees one.
    for (int k = 0; k < 3; k++) begin
      aw(8'h11); cycle();
      check("limit_slot", 32'(obs_aw_id), 32'd0);
    end
    cycle();
    check("limit_stall_valid", 32'(obs_aw_v), 32'd0);
    check("limit_stall_ready", 32'(obs_aw_rdy), 32'd0);
    b(0); cycle();
    check("limit_stall_during_b", 32'(obs_aw_v), 32'd0);
    slave_b_valid = 1'b0; cycle();
    check("limit_resume_valid", 32'(obs_aw_v), 32'd1);
    check("limit_resume_slot", 32'(obs_aw_id), 32'd0);
    drain();

    // Table full: fifth distinct ID waits for a free slot.
    for (int k = 1; k <= 4; k++) begin
      aw(k); cycle();
      check("full_alloc", 32'(obs_aw_id), 32'(k - 1));
    end
    aw(8'h05); cycle();
    check("full_stall", 32'(obs_aw_v), 32'd0);
    b(2); cycle();
    check("full_stall_free_cycle", 32'(obs_aw_v), 32'd0);
    slave_b_valid = 1'b0; cycle();
    check("full_grant_slot", 32'(obs_aw_id), 32'd2);
    check("full_grant_ready", 32'(obs_aw_rdy), 32'd1);
    idle(); b(2); cycle();
    check("full_b_id", 32'(obs_b_id), 32'h05);
    drain();

    // Simultaneous hit and free on slot 1.
    aw(8'h20); cycle();
    aw(8'h07); cycle();
    check("simul_setup", 32'(obs_aw_id), 32'd1);
    aw(8'h07); b(1); cycle();
    check("simul_aw_slot", 32'(obs_aw_id), 32'd1);
    check("simul_b_id", 32'(obs_b_id), 32'h07);
    idle(); b(1); cycle();
    check("simul_next_b_id", 32'(obs_b_id), 32'h07);
    idle(); aw(8'h09); cycle();
    check("simul_slot1_free", 32'(obs_aw_id), 32'd1);
    drain();

    // Read burst: slot held until the last beat.
    master_ar_valid = 1'b1; master_ar_id = 6'h3C; cycle();
    check("rd_ar_slot", 32'(obs_ar_id), 32'd0);
    idle();
    for (int k = 0; k < 3; k++) begin
      slave_r_valid = 1'b1; slave_r_id = 2'd0; slave_r_last = (k == 2);
      master_ar_valid = (k == 1); master_ar_id = 6'h15;
      cycle();
      check("rd_beat_id", 32'(obs_r_id), 32'h3C);
      if (k == 1) check("rd_busy_slot", 32'(obs_ar_id), 32'd1);
    end
    idle(); master_ar_valid = 1'b1; master_ar_id = 6'h16; cycle();
    check("rd_slot0_reuse", 32'(obs_ar_id), 32'd0);
    drain();

    // Mid-operation reset discards live mappings.
    for (int k = 1; k <= 3; k++) begin aw(k); cycle(); end
    idle();
    do_reset("midrst");
    aw(8'h30); cycle();
    check("midrst_alloc", 32'(obs_aw_id), 32'd0);
    check("midrst_ready", 32'(obs_aw_rdy), 32'd1);
    drain();

    // Randomized traffic on a small ID pool so hits, limits and full tables occur.
    for (int n = 0; n < 600; n++) begin
      int s;
      master_aw_valid = ($urandom_range(0, 3) != 0);
      master_aw_id    = MW'($urandom_range(0, 5));
      master_ar_valid = ($urandom_range(0, 3) != 0);
      master_ar_id    = MW'($urandom_range(0, 5));
      slave_aw_ready  = ($urandom_range(0, 3) != 0);
      slave_ar_ready  = ($urandom_range(0, 3) != 0);
      master_b_ready  = ($urandom_range(0, 3) != 0);
      master_r_ready  = ($urandom_range(0, 3) != 0);
      s = $urandom_range(0, N - 1);
      slave_b_id    = SW'(s);
      slave_b_valid = (w_cnt[s] > 0) && ($urandom_range(0, 2) != 0);
      s = $urandom_range(0, N - 1);
      slave_r_id    = SW'(s);
      slave_r_valid = (r_cnt[s] > 0) && ($urandom_range(0, 2) != 0);
      slave_r_last  = ($urandom_range(0, 1) != 0);
      cycle();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
